// File: rtl/ot_driver.sv
// Sends one latched 2x2 complex matrix as 4 beats, then captures and checks the 5-beat det/adjugate reply.
// Latency: first tx beat 1 cycle after start; done 1 cycle after the last rx beat, the gap or the timeout.
// Backpressure: none; rx beats must arrive back-to-back, a gap ends the frame with err_frame.
module ot_driver #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [55:0] mat_in,
    output logic        busy,
    output logic        tx_valid,
    output logic [6:0]  tx_real,
    output logic [6:0]  tx_image,
    input  logic        rx_valid,
    input  logic [8:0]  rx_real,
    input  logic [8:0]  rx_image,
    output logic        done,
    output logic [44:0] res_real,
    output logic [44:0] res_image,
    output logic        err_timeout,
    output logic        err_frame,
    output logic        mismatch
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

    // The 4th tx beat cycle counts as the first idle cycle, so WAIT ends after TIMEOUT-1 more.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [55:0] mat;
    logic [1:0]  tx_idx;
    logic [2:0]  rx_idx;
    logic [7:0]  wait_cnt;
    logic [6:0]  nxt_re;
    logic [6:0]  nxt_im;
    logic [8:0]  exp_re;
    logic [8:0]  exp_im;

    // Sign-extend a 4.3 field to 9 bits, optionally negate, then floor-divide by 8.
    function automatic logic [8:0] scale(input logic [6:0] f, input logic neg);
        logic signed [8:0] s;
        s = {{2{f[6]}}, f};
        if (neg) begin
            s = -s;
        end
        return s >>> 3;
    endfunction

    // Payload of the beat following the one currently on the tx bus (order A, B, C, D).
    always_comb begin
        nxt_re = '0;
        nxt_im = '0;
        case (tx_idx)
            2'd0: begin nxt_re = mat[20:14]; nxt_im = mat[27:21]; end
            2'd1: begin nxt_re = mat[34:28]; nxt_im = mat[41:35]; end
            2'd2: begin nxt_re = mat[48:42]; nxt_im = mat[55:49]; end
            default: ;
        endcase
    end

    // Expected adjugate beat for the slot being received: D, -B, -C, A.
    always_comb begin
        exp_re = '0;
        exp_im = '0;
        case (rx_idx)
            3'd1: begin exp_re = scale(mat[48:42], 1'b0); exp_im = scale(mat[55:49], 1'b0); end
            3'd2: begin exp_re = scale(mat[20:14], 1'b1); exp_im = scale(mat[27:21], 1'b1); end
            3'd3: begin exp_re = scale(mat[34:28], 1'b1); exp_im = scale(mat[41:35], 1'b1); end
            3'd4: begin exp_re = scale(mat[6:0],   1'b0); exp_im = scale(mat[13:7],  1'b0); end
            default: ;
        endcase
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mat         <= '0;
            tx_idx      <= '0;
            rx_idx      <= '0;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            tx_valid    <= 1'b0;
            tx_real     <= '0;
            tx_image    <= '0;
            done        <= 1'b0;
            res_real    <= '0;
            res_image   <= '0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mat         <= mat_in;
                        state       <= SEND;
                        busy        <= 1'b1;
                        tx_valid    <= 1'b1;
                        tx_real     <= mat_in[6:0];
                        tx_image    <= mat_in[13:7];
                        tx_idx      <= '0;
                        rx_idx      <= '0;
                        wait_cnt    <= '0;
                        res_real    <= '0;
                        res_image   <= '0;
                        err_timeout <= 1'b0;
                        err_frame   <= 1'b0;
                        mismatch    <= 1'b0;
                    end
                end
                SEND: begin
                    if (tx_idx != 2'd3) begin
                        tx_idx   <= tx_idx + 2'd1;
                        tx_real  <= nxt_re;
                        tx_image <= nxt_im;
                    end else begin
                        tx_valid <= 1'b0;
                        tx_real  <= '0;
                        tx_image <= '0;
                        wait_cnt <= '0;
                        // A reply overlapping the last tx beat is already the det beat.
                        if (rx_valid) begin
                            res_real[8:0]  <= rx_real;
                            res_image[8:0] <= rx_image;
                            rx_idx         <= 3'd1;
                            state          <= RECV;
                        end else if (TIMEOUT == 1) begin
                            err_timeout <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (rx_valid) begin
                        res_real[8:0]  <= rx_real;
                        res_image[8:0] <= rx_image;
                        rx_idx         <= 3'd1;
                        state          <= RECV;
                    end else if (wait_cnt + 8'd1 == TO_LAST) begin
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        for (int k = 1; k < 5; k++) begin
                            if (3'(k) == rx_idx) begin
                                res_real[9*k +: 9]  <= rx_real;
                                res_image[9*k +: 9] <= rx_image;
                            end
                        end
                        if ({rx_image, rx_real} != {exp_im, exp_re}) begin
                            mismatch <= 1'b1;
                        end
                        if (rx_idx == 3'd4) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        err_frame <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ot_driver.sv
// Bench for ot_driver: per-scenario tasks with a cycle-indexed engine schedule and a reference model.
// The model derives capture window, done cycle, flags and results from the rx schedule alone.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ot_driver;

    localparam int TIMEOUT = 15;
    localparam int MAXC    = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [55:0] mat_in;
    logic        busy;
    logic        tx_valid;
    logic [6:0]  tx_real;
    logic [6:0]  tx_image;
    logic        rx_valid;
    logic [8:0]  rx_real;
    logic [8:0]  rx_image;
    logic        done;
    logic [44:0] res_real;
    logic [44:0] res_image;
    logic        err_timeout;
    logic        err_frame;
    logic        mismatch;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rxv [MAXC];
    logic [8:0] rxr [MAXC];
    logic [8:0] rxi [MAXC];
    logic [8:0] eng_re [8];
    logic [8:0] eng_im [8];

    ot_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mat_in(mat_in),
        .busy(busy), .tx_valid(tx_valid), .tx_real(tx_real), .tx_image(tx_image),
        .rx_valid(rx_valid), .rx_real(rx_real), .rx_image(rx_image),
        .done(done), .res_real(res_real), .res_image(res_image),
        .err_timeout(err_timeout), .err_frame(err_frame), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    function automatic int floor8(input int v);
        if (v >= 0) return v / 8;
        return -((-v + 7) / 8);
    endfunction

    // Expected beat k (1..4) part: D, -B, -C, A scaled by 1/8 with floor.
    function automatic logic [8:0] ref_part(input logic [55:0] m, input int k, input bit im);
        int fld;
        bit neg;
        logic [6:0] f;
        int v;
        case (k)
            1:       begin fld = 3; neg = 1'b0; end
            2:       begin fld = 1; neg = 1'b1; end
            3:       begin fld = 2; neg = 1'b1; end
            default: begin fld = 0; neg = 1'b0; end
        endcase
        f = m[(2*fld + int'(im))*7 +: 7];
        v = int'($signed(f));
        if (neg) v = -v;
        return 9'(floor8(v));
    endfunction

    task automatic clear_rx();
        for (int j = 0; j < MAXC; j++) begin
            rxv[j] = 1'b0;
            rxr[j] = '0;
            rxi[j] = '0;
        end
    endtask

    task automatic set_run(input int s, input int n);
        for (int j = s; j < s + n; j++) begin
            rxv[j] = 1'b1;
            rxr[j] = eng_re[j-s];
            rxi[j] = eng_im[j-s];
        end
    endtask

    task automatic fill_eng_correct(input logic [55:0] m);
        for (int k = 0; k < 8; k++) begin
            eng_re[k] = 9'($urandom);
            eng_im[k] = 9'($urandom);
        end
        for (int k = 1; k < 5; k++) begin
            eng_re[k] = ref_part(m, k, 1'b0);
            eng_im[k] = ref_part(m, k, 1'b1);
        end
    endtask

    // One transaction: start with matrix m, engine follows rxv/rxr/rxi (cycle 0 = first tx beat).
    task automatic do_txn(input logic [55:0] m, input bit spam, input string name);
        int first, cap, dc, last;
        bit e_to, e_fe, e_mm;
        logic [44:0] e_rr, e_ri;
        logic ev;
        logic [6:0] er, ei;
        first = -1;
        for (int j = 3; j < 3 + TIMEOUT; j++)
            if (rxv[j] && first < 0) first = j;
        e_to = 1'b0; e_fe = 1'b0; e_mm = 1'b0; cap = 0; e_rr = '0; e_ri = '0;
        if (first < 0) begin
            e_to = 1'b1;
            dc = 3 + TIMEOUT;
        end else begin
            while (cap < 5 && rxv[first+cap]) cap++;
            if (cap < 5) begin
                e_fe = 1'b1;
                dc = first + cap + 1;
            end else begin
                dc = first + 5;
            end
            for (int k = 0; k < cap; k++) begin
                e_rr[9*k +: 9] = rxr[first+k];
                e_ri[9*k +: 9] = rxi[first+k];
                if (k >= 1 && (rxr[first+k] !== ref_part(m, k, 1'b0) || rxi[first+k] !== ref_part(m, k, 1'b1)))
                    e_mm = 1'b1;
            end
        end
        last = dc + 2;
        for (int j = 0; j < MAXC; j++)
            if (rxv[j] && j + 1 > last) last = j + 1;

        @(negedge clk);
        start = 1'b1;
        mat_in = m;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            ev = (j < 4);
            er = ev ? m[14*j +: 7] : 7'd0;
            ei = ev ? m[14*j+7 +: 7] : 7'd0;
            n_checks++;
            if ({tx_valid, tx_real, tx_image} !== {ev, er, ei}) begin
                n_fail++;
                $display("FAIL %s tx cyc%0d: got v=%b re=%h im=%h, want v=%b re=%h im=%h",
                         name, j, tx_valid, tx_real, tx_image, ev, er, ei);
            end
            n_checks++;
            if (busy !== (j <= dc)) begin
                n_fail++;
                $display("FAIL %s busy cyc%0d: got %b, want %b", name, j, busy, (j <= dc));
            end
            n_checks++;
            if (done !== (j == dc)) begin
                n_fail++;
                $display("FAIL %s done cyc%0d: got %b, want %b", name, j, done, (j == dc));
            end
            if (j == 0) begin
                n_checks++;
                if ({err_timeout, err_frame, mismatch} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL %s flags cleared by start: got %b, want 000", name,
                             {err_timeout, err_frame, mismatch});
                end
            end
            if (j >= dc) begin
                n_checks++;
                if ({err_timeout, err_frame, mismatch} !== {e_to, e_fe, e_mm}) begin
                    n_fail++;
                    $display("FAIL %s flags cyc%0d: got to/fe/mm=%b, want %b", name, j,
                             {err_timeout, err_frame, mismatch}, {e_to, e_fe, e_mm});
                end
                n_checks++;
                if ({res_real, res_image} !== {e_rr, e_ri}) begin
                    n_fail++;
                    $display("FAIL %s res cyc%0d: got re=%h im=%h, want re=%h im=%h", name, j,
                             res_real, res_image, e_rr, e_ri);
                end
            end
            start = spam && (j == 1 || j == 5);
            mat_in = 56'({$urandom, $urandom});
            rx_valid = rxv[j];
            rx_real = rxr[j];
            rx_image = rxi[j];
        end
        start = 1'b0;
        rx_valid = 1'b0;
        rx_real = '0;
        rx_image = '0;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({busy, tx_valid, tx_real, tx_image, done} !== '0) begin
            n_fail++;
            $display("FAIL %s ctrl: got busy=%b txv=%b re=%h im=%h done=%b, want all 0",
                     name, busy, tx_valid, tx_real, tx_image, done);
        end
        n_checks++;
        if ({res_real, res_image, err_timeout, err_frame, mismatch} !== '0) begin
            n_fail++;
            $display("FAIL %s result: got re=%h im=%h flags=%b, want all 0",
                     name, res_real, res_image, {err_timeout, err_frame, mismatch});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; mat_in = '0;
        rx_valid = 1'b0; rx_real = '0; rx_image = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_identity();
        logic [55:0] m;
        // rx activity while idle must be ignored
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_rx: got busy=%b done=%b, want 0 0", busy, done);
            end
            rx_valid = 1'b1; rx_real = 9'h0AA; rx_image = 9'h155;
        end
        m = '0;
        m[6:0] = 7'd8;
        m[48:42] = 7'd8;
        for (int k = 0; k < 8; k++) begin eng_re[k] = '0; eng_im[k] = '0; end
        eng_re[0] = 9'd1; eng_re[1] = 9'd1; eng_re[4] = 9'd1;
        clear_rx();
        set_run(4, 5);
        do_txn(m, 1'b0, "identity");
    endtask

    task automatic test_half();
        logic [55:0] m;
        m = '0;
        m[20:14] = 7'd4;
        for (int k = 0; k < 8; k++) begin eng_re[k] = '0; eng_im[k] = '0; end
        eng_re[2] = 9'h1FF;
        clear_rx();
        set_run(3, 5);
        do_txn(m, 1'b0, "half_ok");
        eng_re[2] = 9'h000;
        clear_rx();
        set_run(3, 5);
        do_txn(m, 1'b0, "half_bad");
    endtask

    task automatic test_timeout();
        clear_rx();
        do_txn(56'({$urandom, $urandom}), 1'b0, "timeout");
    endtask

    task automatic test_frame();
        logic [55:0] m;
        m = 56'({$urandom, $urandom});
        fill_eng_correct(m);
        clear_rx();
        set_run(3, 3);
        do_txn(m, 1'b0, "frame");
    endtask

    task automatic test_start_ignored();
        logic [55:0] m;
        m = 56'({$urandom, $urandom});
        fill_eng_correct(m);
        clear_rx();
        set_run(6, 5);
        do_txn(m, 1'b1, "start_ign");
    endtask

    task automatic test_back_to_back();
        logic [55:0] m;
        for (int i = 0; i < 2; i++) begin
            m = 56'({$urandom, $urandom});
            fill_eng_correct(m);
            clear_rx();
            set_run(1, 7);
            do_txn(m, 1'b0, "b2b");
        end
    endtask

    task automatic test_reset_mid_send();
        logic [55:0] m;
        m = 56'({$urandom, $urandom});
        @(negedge clk);
        start = 1'b1; mat_in = m;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (tx_valid !== 1'b1 || tx_real !== m[20:14]) begin
            n_fail++;
            $display("FAIL rst_mid 2nd beat: got v=%b re=%h, want 1 %h", tx_valid, tx_real, m[20:14]);
        end
        rst_n = 1'b0;
        #1 check_all_zero("rst_mid_async");
        @(posedge clk);
        #2 check_all_zero("rst_mid_held");
        #1 rst_n = 1'b1;
        fill_eng_correct(m);
        clear_rx();
        set_run(5, 5);
        do_txn(m, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        logic [55:0] m;
        int s, n;
        for (int i = 0; i < 25; i++) begin
            m = 56'({$urandom, $urandom});
            fill_eng_correct(m);
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 4);
                eng_re[n] = eng_re[n] ^ 9'($urandom_range(1, 511));
            end
            s = $urandom_range(1, 20);
            n = $urandom_range(0, 7);
            clear_rx();
            set_run(s, n);
            do_txn(m, ($urandom_range(0, 3) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_half();
        test_timeout();
        test_frame();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_send();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ot_driver.md
OT_DRIVER -- requirements
Module: ot_driver

Interface
REQ-001 Parameter TIMEOUT, default 15, max idle cycles in WAIT before abort; legal range 1..255.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to send one matrix; sampled only in IDLE.
REQ-005 mat_in  input  56  2x2 complex matrix, signed 4.3 fixed-point fields:
- A_re [6:0], A_im [13:7]
- B_re [20:14], B_im [27:21]
- C_re [34:28], C_im [41:35]
- D_re [48:42], D_im [55:49]
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 tx_valid  output  1  beat-valid toward the determinant/adjugate engine.
REQ-008 tx_real / tx_image  output  7 each  signed beat payload.
REQ-009 rx_valid  input  1  beat-valid from the engine.
REQ-010 rx_real / rx_image  input  9 each  signed beat payload.
REQ-011 done  output  1  one-cycle pulse at end of every transaction.
REQ-012 res_real / res_image  output  45 each  captured beat k at [9k+8:9k]; k=0 det, 1 D, 2 -B, 3 -C, 4 A.
REQ-013 err_timeout, err_frame, mismatch  output  1 each  status, valid while done=1 and held until next start.

Function
REQ-014 FSM states: IDLE, SEND, WAIT, RECV, DONE.
REQ-015 IDLE: start=1 -> latch mat_in, go to SEND; start in any other state is ignored.
REQ-016 SEND: 4 consecutive cycles with registered tx_valid=1; payload order A, B, C, D; first beat on the cycle after start is sampled.
REQ-017 tx_valid is never deasserted mid-frame; tx_real and tx_image are 0 whenever tx_valid=0.
REQ-018 WAIT: 8-bit cycle counter cleared on entry.
- rx_valid=1 -> capture beat 0, go to RECV.
- counter reaching TIMEOUT with no rx_valid -> set err_timeout, go to DONE.
REQ-019 rx_valid arriving on the same cycle as the 4th tx beat is treated as beat 0.
REQ-020 rx_valid while in IDLE or SEND (before the 4th tx beat) is ignored, with no capture and no error.
REQ-021 RECV: captures beats 1..4 on consecutive cycles.
- rx_valid=0 before beat 4 -> set err_frame, go to DONE; partially captured beats are kept, uncaptured slots are 0.
- After beat 4 -> go to DONE.
REQ-022 Expected values for beats 1..4, computed from the latched matrix:
- beat1 = sext9(D) >>> 3
- beat2 = (-sext9(B)) >>> 3
- beat3 = (-sext9(C)) >>> 3
- beat4 = sext9(A) >>> 3
- All shifts are arithmetic (floor), applied per real/imag part, at 9-bit width with no overflow.
REQ-023 mismatch=1 if any captured beat 1..4 differs from its expected value; beat 0 (det) is not checked.
REQ-024 DONE: done=1 for exactly one cycle, then go to IDLE.
- res_* and status flags stay stable until the next accepted start, which clears the flags.
REQ-025 Latency, fault-free: done rises exactly 1 cycle after beat 4 is captured.
REQ-026 rx_valid high for more than 5 beats: extra beats are ignored, with no error.

Reset
REQ-027 rst_n=0 at any time, including mid-SEND or mid-RECV, immediately forces:
- FSM to IDLE
- busy, tx_valid, done, all error flags = 0
- tx_real, tx_image, res_real, res_image, counters = 0
REQ-028 After rst_n rises, the first start is honoured on the first clock edge.

Verification
REQ-029 Identity matrix, A_re=8, D_re=8, all other fields 0, engine model returns 1,1,0,0,1 -> four tx beats (8,0)(0,0)(0,0)(8,0); res_real beats = 1,1,0,0,1; mismatch=0; done pulses once.
REQ-030 B_re=4 (0.5), engine returns beat2 real=-1 (0x1FF) -> mismatch=0; engine returns 0 instead -> mismatch=1.
REQ-031 Engine silent after SEND, TIMEOUT=15 -> err_timeout=1 and done exactly 15 cycles after the 4th tx beat; res all 0.
REQ-032 Engine drops rx_valid after 3 beats -> err_frame=1; done on the cycle after the gap; beats 3 and 4 of res = 0.
REQ-033 start pulsed during SEND and WAIT -> ignored, so exactly 4 tx beats and one done per transaction.
REQ-034 rst_n asserted during the 2nd tx beat -> tx_valid=0 and busy=0 asynchronously; the next start produces a full, correct transaction.
